// File: rtl/venus_pkg.sv
// rtl/venus_pkg.sv - shared widths, bubble encoding and fetch state type for venus
package venus_pkg;

  localparam int W_INST = 32;
  localparam int W_PC   = 16;
  localparam int W_OPC  = 7;

  // Opcode 0000_100: integer class, no register reservation, so decode treats it as a no-op.
  localparam logic [W_INST-1:0] BUBBLE_INST = 32'h0800_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [W_PC-1:0] pc_inc(input logic [W_PC-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/if_skid.sv
// rtl/if_skid.sv - one-entry {inst, pc} skid buffer with load/unload/clear
module if_skid
  import venus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [W_INST-1:0] inst_in,
  input  logic [W_PC-1:0]   pc_in,
  output logic              full,
  output logic [W_INST-1:0] inst,
  output logic [W_PC-1:0]   pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      inst <= BUBBLE_INST;
      pc   <= '0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      inst <= inst_in;
      pc   <= pc_in;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - venus instruction-fetch stage: PC, imem req/ack, skid and branch flush
module if_fetch
  import venus_pkg::*;
#(
  parameter logic [W_PC-1:0]   RESET_PC = 16'h0000,
  parameter logic [W_INST-1:0] BUBBLE   = BUBBLE_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_PC-1:0]   br_target_i,
  output logic              imem_req_o,
  output logic [W_PC-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [W_INST-1:0] imem_data_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_value_o,
  output logic              valid_o
);

  fetch_state_t      state, state_n;
  logic [W_PC-1:0]   pc_r, pc_n, addr_r, addr_n, pcv_r, pcv_n;
  logic [W_INST-1:0] inst_r, inst_n;
  logic              valid_r, valid_n;
  logic              req;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [W_INST-1:0] skid_inst;
  logic [W_PC-1:0]   skid_pc;

  if_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .inst_in (imem_data_i),
    .pc_in   (addr_r),
    .full    (skid_full),
    .inst    (skid_inst),
    .pc      (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      inst_r  <= BUBBLE;
      pcv_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      addr_r  <= addr_n;
      inst_r  <= inst_n;
      pcv_r   <= pcv_n;
      valid_r <= valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc_r;
    addr_n      = addr_r;
    inst_n      = inst_r;
    pcv_n       = pcv_r;
    valid_n     = valid_r;
    req         = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem_ack_i) begin
          pc_n   = pc_inc(addr_r);
          addr_n = pc_inc(addr_r);
          if (!stall_i) begin
            inst_n  = imem_data_i;
            pcv_n   = addr_r;
            valid_n = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_n   = HOLD;
          end
        end else if (!stall_i) begin
          inst_n  = BUBBLE;
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (!stall_i && skid_full) begin
          inst_n      = skid_inst;
          pcv_n       = skid_pc;
          valid_n     = 1'b1;
          skid_unload = 1'b1;
          addr_n      = pc_r;
          state_n     = FETCH;
        end
      end
      FLUSH: begin
        req = 1'b1;
        if (imem_ack_i) begin
          addr_n  = pc_r;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    // A redirect overrides stall and ack; an outstanding request must still be drained.
    if (br_taken_i) begin
      inst_n      = BUBBLE;
      valid_n     = 1'b0;
      pcv_n       = pcv_r;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      pc_n        = br_target_i;
      if ((state == FETCH || state == FLUSH) && !imem_ack_i) begin
        addr_n  = addr_r;
        state_n = FLUSH;
      end else begin
        addr_n  = br_target_i;
        state_n = FETCH;
      end
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = addr_r;
  assign inst_o      = inst_r;
  assign pc_value_o  = pcv_r;
  assign valid_o     = valid_r;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  localparam logic [31:0] BUB = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br, ack;
  logic [15:0] target;
  logic        req;
  logic [15:0] addr, pcv;
  logic [31:0] data, inst;
  logic        valid;

  logic        rst_w, ack_w, stall_w, br_w;
  logic [15:0] target_w;
  logic        req_w;
  logic [15:0] addr_w, pcv_w;
  logic [31:0] data_w, inst_w;
  logic        valid_w;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address A reads as 32'hC0DE_AAAA.
  assign data   = {16'hC0DE, addr};
  assign data_w = {16'hC0DE, addr_w};

  if_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .br_taken_i(br), .br_target_i(target),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .inst_o(inst), .pc_value_o(pcv), .valid_o(valid)
  );

  if_fetch #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst_w), .stall_i(stall_w), .br_taken_i(br_w), .br_target_i(target_w),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w), .imem_data_i(data_w),
    .inst_o(inst_w), .pc_value_o(pcv_w), .valid_o(valid_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br = 1'b0; ack = 1'b0; target = 16'h0;
    rst_w = 1'b0; ack_w = 1'b1; stall_w = 1'b0; br_w = 1'b0; target_w = 16'h0;

    tick(); tick();
    chk("rst_inst", inst, BUB);
    chk("rst_pcv", {16'h0, pcv}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", {16'h0, addr}, 32'h0);

    // Free run, ack held high.
    rst = 1'b1; ack = 1'b1;
    tick();
    chk("run_req", {31'h0, req}, 32'h1);
    chk("run_addr0", {16'h0, addr}, 32'h0);
    chk("run_valid0", {31'h0, valid}, 32'h0);
    tick();
    chk("run_inst0", inst, 32'hC0DE_0000);
    chk("run_pcv0", {16'h0, pcv}, 32'h0);
    chk("run_valid1", {31'h0, valid}, 32'h1);
    chk("run_addr1", {16'h0, addr}, 32'h1);
    tick();
    chk("run_pcv1", {16'h0, pcv}, 32'h1);
    tick();
    chk("run_pcv2", {16'h0, pcv}, 32'h2);
    chk("run_inst2", inst, 32'hC0DE_0002);
    tick(); tick();
    chk("run_pcv4", {16'h0, pcv}, 32'h4);
    chk("run_addr5", {16'h0, addr}, 32'h5);

    // Stall on the ack cycle at address 5 for three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pcv", {16'h0, pcv}, 32'h4);
      chk("stall_inst", inst, 32'hC0DE_0004);
      chk("stall_valid", {31'h0, valid}, 32'h1);
      chk("stall_req", {31'h0, req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pcv5", {16'h0, pcv}, 32'h5);
    chk("unstall_inst5", inst, 32'hC0DE_0005);
    chk("unstall_addr6", {16'h0, addr}, 32'h6);
    tick();
    chk("unstall_pcv6", {16'h0, pcv}, 32'h6);
    tick();
    chk("pre_br_pcv7", {16'h0, pcv}, 32'h7);
    chk("pre_br_addr8", {16'h0, addr}, 32'h8);

    // Branch while the request at 8 is outstanding; ack arrives two cycles later.
    ack = 1'b0; br = 1'b1; target = 16'h0100;
    tick();
    br = 1'b0;
    chk("flush_valid", {31'h0, valid}, 32'h0);
    chk("flush_inst", inst, BUB);
    chk("flush_pcv", {16'h0, pcv}, 32'h7);
    chk("flush_addr", {16'h0, addr}, 32'h8);
    chk("flush_req", {31'h0, req}, 32'h1);
    tick();
    chk("flush_addr_hold", {16'h0, addr}, 32'h8);
    ack = 1'b1;
    tick();
    chk("flush_done_addr", {16'h0, addr}, 32'h0100);
    chk("flush_discard", {31'h0, valid}, 32'h0);
    chk("flush_discard_inst", inst, BUB);
    tick();
    chk("tgt_pcv", {16'h0, pcv}, 32'h0100);
    chk("tgt_inst", inst, 32'hC0DE_0100);
    chk("tgt_valid", {31'h0, valid}, 32'h1);

    // Branch coinciding with ack and stall: branch wins, no skid load.
    br = 1'b1; stall = 1'b1; target = 16'h0200;
    tick();
    br = 1'b0; stall = 1'b0;
    chk("bas_valid", {31'h0, valid}, 32'h0);
    chk("bas_inst", inst, BUB);
    chk("bas_pcv", {16'h0, pcv}, 32'h0100);
    chk("bas_addr", {16'h0, addr}, 32'h0200);
    chk("bas_req", {31'h0, req}, 32'h1);
    tick();
    chk("bas_next_pcv", {16'h0, pcv}, 32'h0200);
    chk("bas_next_inst", inst, 32'hC0DE_0200);

    // Missing ack without stall yields a bubble, address stays put.
    ack = 1'b0;
    tick();
    chk("noack_valid", {31'h0, valid}, 32'h0);
    chk("noack_inst", inst, BUB);
    chk("noack_pcv", {16'h0, pcv}, 32'h0200);
    chk("noack_addr", {16'h0, addr}, 32'h0201);

    // Reset mid-FLUSH with an ack in the same cycle.
    br = 1'b1; target = 16'h0300;
    tick();
    br = 1'b0;
    chk("pre_rst_flush_addr", {16'h0, addr}, 32'h0201);
    rst = 1'b0; ack = 1'b1;
    tick();
    chk("mrst_inst", inst, BUB);
    chk("mrst_pcv", {16'h0, pcv}, 32'h0);
    chk("mrst_valid", {31'h0, valid}, 32'h0);
    chk("mrst_req", {31'h0, req}, 32'h0);
    chk("mrst_addr", {16'h0, addr}, 32'h0);
    rst = 1'b1;
    tick();
    chk("mrst_first_req", {31'h0, req}, 32'h1);
    chk("mrst_first_addr", {16'h0, addr}, 32'h0);

    // PC wrap on the RESET_PC=FFFE instance.
    rst_w = 1'b1;
    tick();
    chk("wrap_addr", {16'h0, addr_w}, 32'hFFFE);
    tick();
    chk("wrap_pcv_fffe", {16'h0, pcv_w}, 32'hFFFE);
    chk("wrap_valid", {31'h0, valid_w}, 32'h1);
    tick();
    chk("wrap_pcv_ffff", {16'h0, pcv_w}, 32'hFFFF);
    tick();
    chk("wrap_pcv_0000", {16'h0, pcv_w}, 32'h0000);
    chk("wrap_inst_0000", inst_w, 32'hC0DE_0000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
